// File: rtl/channel_group_acc_pkg.sv
// ============================================================================
// channel_group_acc_pkg
// Shared lane geometry, accumulator default width and FSM encoding for the
// channel-group accumulator. The two platform macros are given fallback
// values so the slice compiles stand-alone when no platform header is present.
// Revision: 1.0
// ============================================================================
`default_nettype none

`ifndef PICTURE_NUM
`define PICTURE_NUM 4
`endif

`ifndef WIDTH_DATA_OUT
`define WIDTH_DATA_OUT 8
`endif

package channel_group_acc_pkg;

    // Number of independent signed lanes carried per pixel vector
    localparam int LANES     = `PICTURE_NUM;
    // Width of one adder-tree partial-sum lane on the input side
    localparam int IN_W      = 2 * `WIDTH_DATA_OUT;
    // Default accumulator lane width: 8 guard bits above the input lane
    localparam int ACC_W_DEF = 2 * `WIDTH_DATA_OUT + 8;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/channel_group_acc_psum_ram.sv
// ============================================================================
// psum_ram
// Simple dual-port partial-sum buffer: one write port, one synchronous read
// port with one cycle of latency. A read of the address being written in the
// same cycle returns the old contents. No reset, so it maps to block RAM.
// Revision: 1.0
// ============================================================================
`default_nettype none

module psum_ram #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 96,
    parameter int AW    = 8
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Registered read and write; read-first on an address collision
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

`default_nettype wire

// File: rtl/channel_group_acc.sv
// ============================================================================
// channel_group_acc
// Accumulates adder-tree partial sums over channel-in groups, per pixel
// position and per lane. Group 0 seeds the buffer, middle groups read-add-
// write, and the last group emits the final sums two cycles after its input.
// Revision: 1.0
// ============================================================================
`default_nettype none

module channel_group_acc
    import channel_group_acc_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int ACC_W = 2 * `WIDTH_DATA_OUT + 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_pixels,
    input  logic [CNT_W-1:0]       num_groups,
    input  logic                   valid_in,
    input  logic [LANES*IN_W-1:0]  data_in,
    output logic                   busy,
    output logic                   valid_out,
    output logic [LANES*ACC_W-1:0] data_out,
    output logic                   done
);

    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OUT_W = LANES * ACC_W;

    state_t             state;
    logic [CNT_W-1:0]   cfg_pixels;
    logic [CNT_W-1:0]   cfg_groups;
    logic [CNT_W-1:0]   pix_cnt;
    logic [CNT_W-1:0]   grp_cnt;

    logic               start_ok;
    logic               accept;
    logic               last_pix;
    logic               last_grp;
    logic               run_next;
    logic [AW-1:0]      pix_addr;

    // Stage 1: the accepted input waits here while the buffer read completes
    logic               s1_valid;
    logic               s1_first;
    logic               s1_last;
    logic               s1_done;
    logic [AW-1:0]      s1_addr;
    logic [LANES*IN_W-1:0] s1_data;

    // Copy of the previous cycle's buffer write, used to bypass the RAM when
    // the next access targets the same pixel before the write is visible
    logic               fwd_valid;
    logic [AW-1:0]      fwd_addr;
    logic [OUT_W-1:0]   fwd_sum;

    logic [OUT_W-1:0]   rd_data;
    logic [OUT_W-1:0]   operand;
    logic [OUT_W-1:0]   sum;

    assign start_ok = start && (state == ST_IDLE);
    assign accept   = valid_in && (state == ST_RUN);
    assign last_pix = (pix_cnt == cfg_pixels);
    assign last_grp = (grp_cnt == cfg_groups);
    assign pix_addr = AW'(pix_cnt);

    // The tile is still running next cycle unless its final input is taken now
    assign run_next = start_ok ||
                      ((state == ST_RUN) && !(accept && last_pix && last_grp));

    // Control FSM: configuration capture and pixel/group position counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cfg_pixels <= '0;
            cfg_groups <= '0;
            pix_cnt    <= '0;
            grp_cnt    <= '0;
        end else if (state == ST_IDLE) begin
            if (start) begin
                state      <= ST_RUN;
                cfg_pixels <= num_pixels;
                cfg_groups <= num_groups;
                pix_cnt    <= '0;
                grp_cnt    <= '0;
            end
        end else if (valid_in) begin
            if (last_pix) begin
                pix_cnt <= '0;
                if (last_grp) begin
                    state   <= ST_IDLE;
                    grp_cnt <= '0;
                end else begin
                    grp_cnt <= grp_cnt + CNT_W'(1);
                end
            end else begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
        end
    end

    psum_ram #(
        .DEPTH (DEPTH),
        .WIDTH (OUT_W),
        .AW    (AW)
    ) u_psum_ram (
        .clk     (clk),
        .wr_en   (s1_valid),
        .wr_addr (s1_addr),
        .wr_data (sum),
        .rd_addr (pix_addr),
        .rd_data (rd_data)
    );

    // Select the running sum: zero for group 0, bypassed value on a hazard
    always_comb begin
        operand = '0;
        if (!s1_first) begin
            if (fwd_valid && (fwd_addr == s1_addr)) begin
                operand = fwd_sum;
            end else begin
                operand = rd_data;
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [ACC_W-1:0] lane_ext;
        assign lane_ext = {{(ACC_W-IN_W){s1_data[l*IN_W+IN_W-1]}},
                           s1_data[l*IN_W +: IN_W]};
        assign sum[l*ACC_W +: ACC_W] = operand[l*ACC_W +: ACC_W] + lane_ext;
    end

    // Datapath pipeline, bypass register and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_first  <= 1'b0;
            s1_last   <= 1'b0;
            s1_done   <= 1'b0;
            s1_addr   <= '0;
            s1_data   <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_sum   <= '0;
            valid_out <= 1'b0;
            done      <= 1'b0;
            data_out  <= '0;
            busy      <= 1'b0;
        end else begin
            s1_valid  <= accept;
            s1_first  <= (grp_cnt == '0);
            s1_last   <= last_grp;
            s1_done   <= last_grp && last_pix;
            s1_addr   <= pix_addr;
            s1_data   <= data_in;

            fwd_valid <= s1_valid;
            fwd_addr  <= s1_addr;
            fwd_sum   <= sum;

            valid_out <= s1_valid && s1_last;
            done      <= s1_valid && s1_last && s1_done;
            if (s1_valid && s1_last) begin
                data_out <= sum;
            end

            // Busy covers the running tile plus the two in-flight result stages
            busy <= run_next || accept || (s1_valid && s1_last);
        end
    end

endmodule

`default_nettype wire

// File: doc/channel_group_acc.md
CHANNEL_GROUP_ACC -- requirements
Module: channel_group_acc

Interface
REQ-001 Parameter DEPTH, default 256: maximum pixel positions per tile, and the depth of the partial-sum buffer.
REQ-002 Parameter ACC_W, default 2*`WIDTH_DATA_OUT+8: signed accumulator lane width.
REQ-003 Parameter CNT_W, default 8: width of the num_pixels and num_groups configuration fields.
REQ-004 clk  in  1: single clock, all logic on the rising edge.
REQ-005 rst_n  in  1: reset, asynchronous, active-low.
REQ-006 start  in  1: one-cycle pulse that latches the configuration and begins a tile.
REQ-007 num_pixels  in  CNT_W: number of pixel vectors per channel group, minus one (range 0..DEPTH-1).
REQ-008 num_groups  in  CNT_W: number of channel-in groups, minus one.
REQ-009 valid_in  in  1: qualifies data_in; there is no backpressure.
REQ-010 data_in  in  `PICTURE_NUM*`WIDTH_DATA_OUT*2: adder-tree partial sums, `PICTURE_NUM signed lanes of 2*`WIDTH_DATA_OUT bits each.
REQ-011 busy  out  1: high from the accepted start until the last output has been issued.
REQ-012 valid_out  out  1: qualifies data_out.
REQ-013 data_out  out  `PICTURE_NUM*ACC_W: final per-pixel sums over all channel groups, as signed lanes.
REQ-014 done  out  1: one-cycle pulse coincident with the last valid_out of a tile.

Function
REQ-015 FSM states are IDLE and RUN. IDLE->RUN on start; RUN->IDLE when the last pixel of the last group is accepted.
REQ-016 Configuration is latched on start in IDLE. Start in RUN is ignored, and so is valid_in in IDLE.
REQ-017 Counters: pix_cnt increments on each accepted valid_in and wraps to 0 after num_pixels. grp_cnt increments on each pix_cnt wrap.
REQ-018 Group 0 behaviour: each input lane is sign-extended to ACC_W and written to buffer[pix_cnt]; no read is used.
REQ-019 Groups 1..num_groups-1 behaviour: buffer[pix_cnt] is read, the sign-extended input lane is added per lane, and the result is written back.
REQ-020 Last group behaviour: read plus add as in REQ-019; the sum drives data_out with valid_out=1, and the buffer write is optional.
REQ-021 num_groups=0: data_out equals the sign-extended data_in, with the same latency.
REQ-022 Arithmetic: per-lane two's-complement addition modulo 2^ACC_W, with no saturation and no lane carry crossing.
REQ-023 Latency: valid_out is asserted exactly 2 cycles after the accepted valid_in of the last group (1 cycle buffer read, 1 cycle add/register).
REQ-024 Read-after-write hazard: when num_pixels=0 or 1 with back-to-back valid_in, the in-flight sum SHALL be forwarded so results equal the ideal sum.
REQ-025 Gaps: valid_in may deassert for any number of cycles inside a tile; counters and the pipeline hold their state.
REQ-026 busy falls in the cycle after done.
REQ-027 A start arriving in that same cycle is accepted.

Reset
REQ-028 rst_n low forces the FSM to IDLE, clears all counters and pipeline valids, and sets busy=0, valid_out=0, done=0, data_out=0.
REQ-029 Reset mid-tile aborts the tile; no valid_out follows. Buffer contents are don't-care and are not cleared.

Structure
REQ-030 PICTURE_NUM and WIDTH_DATA_OUT come from the shared Para.v macros.
REQ-031 FSM state encodings and the ACC_W default belong in Para.v.
REQ-032 The buffer is one sub-module, psum_ram: simple dual-port, DEPTH x `PICTURE_NUM*ACC_W, synchronous read with 1-cycle latency, no reset, inferable as block RAM.

Verification
REQ-033 Scenario: PICTURE_NUM lanes, num_pixels=3, num_groups=2, lane value = group+1 -> four valid_out vectors, all lanes 6, done on the 4th, busy low the cycle after.
REQ-034 Scenario: num_groups=0, data_in lane = -5 -> data_out lane = -5 sign-extended, 2-cycle latency.
REQ-035 Scenario: num_pixels=0, num_groups=7, back-to-back valid_in, lane = 100 -> single output, lane = 800 (exercises forwarding).
REQ-036 Scenario: random valid_in gaps, random signed lanes, num_pixels=DEPTH-1, num_groups=15 -> outputs match the reference-model sums in pixel order.
REQ-037 Scenario: lane values 0x7FFF-scale maxima over 256 groups -> modulo-2^ACC_W wrap matches the model, with no lane-to-lane corruption.
REQ-038 Scenario: rst_n pulsed low mid-group-1, then a new start -> no stale valid_out, and the new tile's results are correct.
